sram_fault_model: RTL

//  Memory-side responder for the MBIST interface: a synchronous single-port ADDR_W x DATA_W RAM.
//  It answers the cs/rwbar/address/datain requests issued by the BIST engine or the normal-mode mux.
//  A post-reset init sequencer clears every word before the RAM accepts accesses.
//  A programmable single-fault engine (stuck-at-0, stuck-at-1, rising-transition fault) gives

---
 rtl/mem_bist_pkg.sv | 26 ++
 rtl/sram_fault_inj.sv | 30 +++
 rtl/sram_fault_model.sv | 98 +++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types for the MBIST memory responder and its fault engine
package mem_bist_pkg;

    localparam int PKG_ADDR_W = 6;
    localparam int PKG_DATA_W = 8;
    localparam int PKG_BIT_W  = $clog2(PKG_DATA_W);

    typedef enum logic [1:0] {
        FLT_NONE  = 2'd0,
        FLT_SA0   = 2'd1,
        FLT_SA1   = 2'd2,
        FLT_TF_UP = 2'd3
    } fault_type_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_BIT_W-1:0]  bit_idx;
        fault_type_e           ftype;
    } fault_desc_t;

endpackage

// File: rtl/sram_fault_inj.sv
// sram_fault_inj: applies a single-bit fault descriptor to the write and read paths of one word
module sram_fault_inj
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = PKG_ADDR_W,
    parameter int DATA_W = PKG_DATA_W
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  fault_desc_t       desc,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wr_word,
    output logic [DATA_W-1:0] rd_word
);

    logic [DATA_W-1:0] m;

    // select the faulty bit only when the access hits the faulty word
    always_comb begin
        m       = (desc.addr == address) ? (DATA_W'(1) << desc.bit_idx) : '0;
        wr_word = (desc.ftype == FLT_SA0)   ? (new_word & ~m) :
                  (desc.ftype == FLT_SA1)   ? (new_word | m) :
                  (desc.ftype == FLT_TF_UP) ? (new_word & ~(m & ~old_word)) :
                                              new_word;
        rd_word = (desc.ftype == FLT_SA0) ? (old_word & ~m) :
                  (desc.ftype == FLT_SA1) ? (old_word | m) :
                                            old_word;
    end

endmodule

// File: rtl/sram_fault_model.sv
// sram_fault_model: single-port RAM with post-reset clear and optional single-fault engine (FAULT_INJECT_EN)
module sram_fault_model
    import mem_bist_pkg::*;
#(
    parameter int               ADDR_W   = PKG_ADDR_W,
    parameter int               DATA_W   = PKG_DATA_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cs,
    input  logic                      rwbar,
    input  logic [ADDR_W-1:0]         address,
    input  logic [DATA_W-1:0]         datain,
    output logic [DATA_W-1:0]         dataout,
    output logic                      ready,
    input  logic                      flt_we,
    input  logic [ADDR_W-1:0]         flt_addr,
    input  logic [$clog2(DATA_W)-1:0] flt_bit,
    input  logic [1:0]                flt_type,
    output logic                      flt_active
);

    ram_state_e        state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] old_word, wr_word, rd_word;
    logic              access;

    assign ready    = (state == ST_READY);
    assign access   = ready && cs;
    assign old_word = mem[address];

    // state and init pointer register; reset always restarts the clear sweep from word 0
    always_ff @(posedge clk) begin
        state <= rst ? ST_INIT : state_nx;
        ptr   <= rst ? '0 : (state == ST_INIT) ? ptr + 1'b1 : ptr;
    end

    // leave INIT right after the last word has been cleared
    always_comb begin
        state_nx = state;
        state_nx = (state == ST_INIT && &ptr) ? ST_READY : state;
    end

    // array write port: init sweep has priority, user writes only once ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT)
                mem[ptr] <= INIT_VAL;
            else if (cs && !rwbar)
                mem[address] <= wr_word;
        end
    end

    // registered read data, held whenever no read is honoured
    always_ff @(posedge clk) begin
        if (rst)
            dataout <= '0;
        else if (access && rwbar)
            dataout <= rd_word;
    end

`ifdef FAULT_INJECT_EN
    fault_desc_t desc;

    // descriptor load; an access in the same cycle still sees the previous descriptor
    always_ff @(posedge clk) begin
        if (rst) begin
            desc       <= '{addr: '0, bit_idx: '0, ftype: FLT_NONE};
            flt_active <= 1'b0;
        end else if (flt_we) begin
            desc       <= '{addr: flt_addr, bit_idx: flt_bit, ftype: fault_type_e'(flt_type)};
            flt_active <= (flt_type != 2'd0);
        end
    end

    sram_fault_inj #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_inj (
        .old_word (old_word),
        .new_word (datain),
        .desc     (desc),
        .address  (address),
        .wr_word  (wr_word),
        .rd_word  (rd_word)
    );
`else
    logic unused_flt;

    assign unused_flt = ^{flt_we, flt_addr, flt_bit, flt_type};
    assign wr_word    = datain;
    assign rd_word    = old_word;
    assign flt_active = 1'b0;
`endif

endmodule
